// File: rtl/ioctl_host_xfer.sv
// ioctl_host_xfer: host-side initiator for the ioctl loader bus.
// Download bytes become ioctl_wr strobes; upload reads feed a sink stream.
module ioctl_host_xfer #(
    parameter int ADDR_W = 25,
    parameter int RD_LAT = 2,
    parameter int WR_GAP = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_upload,
    input  logic [7:0]        cmd_index,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              busy,
    output logic              done,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [7:0]        snk_data,
    output logic              snk_valid,
    input  logic              snk_ready,
    output logic              ioctl_download,
    output logic              ioctl_upload,
    output logic [7:0]        ioctl_index,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic              ioctl_wr,
    input  logic [7:0]        ioctl_din,
    input  logic              ioctl_wait
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        DL_FETCH,
        DL_WRITE,
        DL_GAP,
        UL_ADDR,
        UL_WAIT,
        UL_PUSH,
        FINISH
    } state_t;

    state_t            state, state_n;
    logic              busy_n, done_n, src_ready_n;
    logic [7:0]        snk_data_n;
    logic              snk_valid_n;
    logic              dl_n, ul_n;
    logic [7:0]        index_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        dout_n;
    logic              wr_n;
    logic [ADDR_W-1:0] len_q, len_n;
    logic [LAT_W-1:0]  lat_cnt, lat_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic              last_byte;
    logic              src_fire;
    logic              snk_fire;

    assign last_byte = (ioctl_addr == len_q - ADDR_W'(1));
    assign src_fire  = src_valid & src_ready;
    assign snk_fire  = snk_valid & snk_ready;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            src_ready      <= 1'b0;
            snk_data       <= '0;
            snk_valid      <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_upload   <= 1'b0;
            ioctl_index    <= '0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_wr       <= 1'b0;
            len_q          <= '0;
            lat_cnt        <= '0;
            gap_cnt        <= '0;
        end else begin
            state          <= state_n;
            busy           <= busy_n;
            done           <= done_n;
            src_ready      <= src_ready_n;
            snk_data       <= snk_data_n;
            snk_valid      <= snk_valid_n;
            ioctl_download <= dl_n;
            ioctl_upload   <= ul_n;
            ioctl_index    <= index_n;
            ioctl_addr     <= addr_n;
            ioctl_dout     <= dout_n;
            ioctl_wr       <= wr_n;
            len_q          <= len_n;
            lat_cnt        <= lat_n;
            gap_cnt        <= gap_n;
        end
    end

    always_comb begin
        state_n     = state;
        busy_n      = busy;
        done_n      = 1'b0;
        src_ready_n = src_ready;
        snk_data_n  = snk_data;
        snk_valid_n = snk_valid;
        dl_n        = ioctl_download;
        ul_n        = ioctl_upload;
        index_n     = ioctl_index;
        addr_n      = ioctl_addr;
        dout_n      = ioctl_dout;
        wr_n        = 1'b0;
        len_n       = len_q;
        lat_n       = lat_cnt;
        gap_n       = gap_cnt;

        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    busy_n  = 1'b1;
                    index_n = cmd_index;
                    len_n   = cmd_len;
                    addr_n  = '0;
                    lat_n   = '0;
                    if (cmd_len == '0) begin
                        state_n = FINISH;
                    end else if (cmd_upload) begin
                        ul_n    = 1'b1;
                        state_n = UL_ADDR;
                    end else begin
                        dl_n        = 1'b1;
                        src_ready_n = 1'b1;
                        state_n     = DL_FETCH;
                    end
                end
            end
            // Strobe is launched on the capture edge when the
            // target is not stalling, giving 2+WR_GAP cycles/byte.
            DL_FETCH: begin
                if (src_fire) begin
                    dout_n      = src_data;
                    src_ready_n = 1'b0;
                    wr_n        = !ioctl_wait;
                    state_n     = DL_WRITE;
                end
            end
            DL_WRITE: begin
                if (ioctl_wr) begin
                    if (last_byte) begin
                        dl_n    = 1'b0;
                        state_n = FINISH;
                    end else begin
                        addr_n = ioctl_addr + ADDR_W'(1);
                        if (WR_GAP == 0) begin
                            src_ready_n = 1'b1;
                            state_n     = DL_FETCH;
                        end else begin
                            gap_n   = '0;
                            state_n = DL_GAP;
                        end
                    end
                end else if (!ioctl_wait) begin
                    wr_n = 1'b1;
                end
            end
            DL_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    src_ready_n = 1'b1;
                    state_n     = DL_FETCH;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            UL_ADDR, UL_WAIT: begin
                if (!ioctl_wait) begin
                    if (lat_cnt == LAT_LAST) begin
                        snk_data_n  = ioctl_din;
                        snk_valid_n = 1'b1;
                        state_n     = UL_PUSH;
                    end else begin
                        lat_n   = lat_cnt + LAT_W'(1);
                        state_n = UL_WAIT;
                    end
                end
            end
            UL_PUSH: begin
                if (snk_fire) begin
                    snk_valid_n = 1'b0;
                    if (last_byte) begin
                        ul_n    = 1'b0;
                        state_n = FINISH;
                    end else begin
                        addr_n  = ioctl_addr + ADDR_W'(1);
                        lat_n   = '0;
                        state_n = UL_ADDR;
                    end
                end
            end
            FINISH: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ioctl_host_xfer.sv
// tb_ioctl_host_xfer: scoreboard bench for ioctl_host_xfer.
// Source/sink stimulus with a 2-stage read-latency target model.
module tb_ioctl_host_xfer;

    localparam int AW  = 25;
    localparam int GAP = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_start = 1'b0;
    logic          cmd_upload = 1'b0;
    logic [7:0]    cmd_index = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          busy, done;
    logic [7:0]    src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [7:0]    snk_data;
    logic          snk_valid;
    logic          snk_ready = 1'b1;
    logic          ioctl_download, ioctl_upload;
    logic [7:0]    ioctl_index;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic [7:0]    ioctl_din = '0;
    logic          ioctl_wait = 1'b0;
    logic [7:0]    rd_p1 = '0;

    exp_t       exp_q[$];
    logic [7:0] up_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    ioctl_host_xfer #(.ADDR_W(AW), .RD_LAT(2), .WR_GAP(GAP)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cmd_start(cmd_start), .cmd_upload(cmd_upload),
        .cmd_index(cmd_index), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait)
    );

    always #5 clk_sys = ~clk_sys;

    // Target RAM: din = 0x10 + addr, two register stages behind the address
    always @(posedge clk_sys) begin
        rd_p1     <= 8'h10 + ioctl_addr[7:0];
        ioctl_din <= rd_p1;
    end

    task automatic start_cmd(input logic up, input logic [7:0] idx,
                             input logic [AW-1:0] len);
        cmd_upload = up;
        cmd_index  = idx;
        cmd_len    = len;
        cmd_start  = 1'b1;
        @(posedge clk_sys); #1;
        cmd_start  = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_cmp++;
        if ({busy, done, src_ready, snk_valid, ioctl_download,
             ioctl_upload, ioctl_wr} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {busy, done, src_ready,
                     snk_valid, ioctl_download, ioctl_upload, ioctl_wr});
        end
        n_cmp++;
        if ({ioctl_addr, ioctl_index, ioctl_dout, snk_data} !== {(AW+24){1'b0}}) begin
            n_bad++;
            $display("FAIL reset_data: got addr %0h idx %0h dout %0h snk %0h want 0",
                     ioctl_addr, ioctl_index, ioctl_dout, snk_data);
        end
        reset = 1'b1;
        ioctl_wait = 1'b1;
        repeat (4) @(negedge clk_sys);
        n_cmp++;
        if ({busy, done, ioctl_wr, src_ready} !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_wait: got %b want 0", {busy, done, ioctl_wr, src_ready});
        end
        ioctl_wait = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic test_download();
        logic [7:0] bytes [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        exp_t e;
        int k = 0, nwr = 0, ndone = 0, last = 0, dl_low = 0, inv = 0, tail = -1;
        logic fire;
        exp_q.delete();
        src_data  = bytes[0];
        src_valid = 1'b1;
        start_cmd(1'b0, 8'h05, AW'(4));
        for (int cyc = 0; cyc < 200 && tail != 0; cyc++) begin
            @(negedge clk_sys);
            if (ioctl_wr && !ioctl_download) inv++;
            if (nwr < 4 && !ioctl_download) dl_low++;
            if (ioctl_wr) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL dl_extra_wr: got wr at %0h want none", ioctl_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ioctl_addr, ioctl_dout} !== {e.addr, e.data}) begin
                        n_bad++;
                        $display("FAIL dl_wr: got %0h/%0h want %0h/%0h",
                                 ioctl_addr, ioctl_dout, e.addr, e.data);
                    end
                end
                if (nwr > 0) begin
                    n_cmp++;
                    if (cyc - last !== 2 + GAP) begin
                        n_bad++;
                        $display("FAIL dl_spacing: got %0d want %0d", cyc - last, 2 + GAP);
                    end
                end
                last = cyc;
                nwr++;
            end
            if (done) begin
                ndone++;
                if (tail < 0) tail = 5;
            end
            if (tail > 0) tail--;
            fire = src_valid && src_ready;
            if (fire && k < 4) begin
                e.addr = AW'(k);
                e.data = bytes[k];
                exp_q.push_back(e);
            end
            @(posedge clk_sys); #1;
            if (fire) begin
                k++;
                if (k < 4) src_data = bytes[k];
                else src_valid = 1'b0;
            end
        end
        n_cmp++;
        if (nwr !== 4) begin
            n_bad++; $display("FAIL dl_count: got %0d want 4", nwr);
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++; $display("FAIL dl_done: got %0d want 1", ndone);
        end
        n_cmp++;
        if ({busy, ioctl_download} !== 2'b00) begin
            n_bad++; $display("FAIL dl_end: got %b want 00", {busy, ioctl_download});
        end
        n_cmp++;
        if (dl_low + inv !== 0) begin
            n_bad++; $display("FAIL dl_level: got %0d/%0d want 0/0", dl_low, inv);
        end
    endtask

    task automatic test_wait();
        logic [7:0] bytes [3] = '{8'hB0, 8'hB1, 8'hB2};
        exp_t e;
        int k = 0, nwr = 0, ndone = 0, viol = 0, wleft = 0, tail = -1;
        logic fire, arm = 1'b0, rel = 1'b0, chk = 1'b0, prev = 1'b0;
        exp_q.delete();
        src_data  = bytes[0];
        src_valid = 1'b1;
        start_cmd(1'b0, 8'h06, AW'(3));
        for (int cyc = 0; cyc < 200 && tail != 0; cyc++) begin
            @(negedge clk_sys);
            if (ioctl_wr && (ioctl_wait || prev)) viol++;
            prev = ioctl_wr;
            if (ioctl_wr) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wt_extra_wr: got wr at %0h want none", ioctl_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ioctl_addr, ioctl_dout} !== {e.addr, e.data}) begin
                        n_bad++;
                        $display("FAIL wt_wr: got %0h/%0h want %0h/%0h",
                                 ioctl_addr, ioctl_dout, e.addr, e.data);
                    end
                end
                if (rel && !chk) begin
                    chk = 1'b1;
                    n_cmp++;
                    if ({ioctl_addr, ioctl_dout} !== {AW'(1), 8'hB1}) begin
                        n_bad++;
                        $display("FAIL wt_release: got %0h/%0h want 1/b1",
                                 ioctl_addr, ioctl_dout);
                    end
                end
                if (nwr == 0) arm = 1'b1;
                nwr++;
            end
            if (done) begin
                ndone++;
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
            fire = src_valid && src_ready;
            if (fire && k < 3) begin
                e.addr = AW'(k);
                e.data = bytes[k];
                exp_q.push_back(e);
            end
            @(posedge clk_sys); #1;
            if (fire) begin
                k++;
                if (k < 3) src_data = bytes[k];
                else src_valid = 1'b0;
            end
            if (arm) begin
                arm = 1'b0;
                ioctl_wait = 1'b1;
                wleft = 5;
            end else if (wleft > 0) begin
                wleft--;
                if (wleft == 0) begin
                    ioctl_wait = 1'b0;
                    rel = 1'b1;
                end
            end
        end
        ioctl_wait = 1'b0;
        n_cmp++;
        if (viol !== 0) begin
            n_bad++; $display("FAIL wt_stall_wr: got %0d want 0", viol);
        end
        n_cmp++;
        if (!chk || nwr !== 3) begin
            n_bad++; $display("FAIL wt_count: got %0d/%0b want 3/1", nwr, chk);
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++; $display("FAIL wt_done: got %0d want 1", ndone);
        end
    endtask

    task automatic test_upload();
        logic [7:0] eb;
        int nrx = 0, ndone = 0, stall = 0, dl_hi = 0, ul_low = 0, tail = -1;
        logic fire;
        up_q.delete();
        for (int i = 0; i < 3; i++) up_q.push_back(8'h10 + 8'(i));
        src_valid = 1'b0;
        snk_ready = 1'b1;
        start_cmd(1'b1, 8'h22, AW'(3));
        for (int cyc = 0; cyc < 200 && tail != 0; cyc++) begin
            @(negedge clk_sys);
            if (ioctl_download) dl_hi++;
            if (nrx < 3 && !ioctl_upload) ul_low++;
            fire = snk_valid && snk_ready;
            if (fire) begin
                n_cmp++;
                if (up_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ul_extra: got %0h want none", snk_data);
                end else begin
                    eb = up_q.pop_front();
                    if (snk_data !== eb) begin
                        n_bad++;
                        $display("FAIL ul_data: got %0h want %0h", snk_data, eb);
                    end
                end
                nrx++;
            end else if (snk_valid && up_q.size() > 0) begin
                stall++;
                n_cmp++;
                if ({ioctl_addr, snk_data} !== {AW'(1), up_q[0]}) begin
                    n_bad++;
                    $display("FAIL ul_hold: got %0h/%0h want 1/%0h",
                             ioctl_addr, snk_data, up_q[0]);
                end
            end
            if (done) begin
                ndone++;
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
            @(posedge clk_sys); #1;
            if (fire && nrx == 1) snk_ready = 1'b0;
            else if (!snk_ready && stall == 3) snk_ready = 1'b1;
        end
        snk_ready = 1'b1;
        n_cmp++;
        if (nrx !== 3 || stall !== 3) begin
            n_bad++; $display("FAIL ul_count: got %0d/%0d want 3/3", nrx, stall);
        end
        n_cmp++;
        if (ndone !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL ul_done: got %0d/%b want 1/0", ndone, busy);
        end
        n_cmp++;
        if (dl_hi + ul_low !== 0 || ioctl_upload !== 1'b0) begin
            n_bad++;
            $display("FAIL ul_level: got %0d/%0d/%b want 0/0/0", dl_hi, ul_low, ioctl_upload);
        end
        n_cmp++;
        if (ioctl_index !== 8'h22) begin
            n_bad++; $display("FAIL ul_index: got %0h want 22", ioctl_index);
        end
    endtask

    task automatic test_zero_len();
        int ndone = 0, nstr = 0;
        src_valid = 1'b0;
        start_cmd(1'b0, 8'h44, AW'(0));
        repeat (12) begin
            @(negedge clk_sys);
            if (done) ndone++;
            if (ioctl_wr || ioctl_download || ioctl_upload || src_ready) nstr++;
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_bad++; $display("FAIL zl_done: got %0d want 1", ndone);
        end
        n_cmp++;
        if (nstr !== 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL zl_strobe: got %0d/%b want 0/0", nstr, busy);
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic test_reset_abort();
        logic [7:0] bytes [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        logic [7:0] nb [2] = '{8'hD0, 8'hD1};
        exp_t e;
        int k = 0, nwr = 0, ndone = 0, tail = -1;
        logic fire;
        exp_q.delete();
        src_data  = bytes[0];
        src_valid = 1'b1;
        start_cmd(1'b0, 8'h5A, AW'(4));
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk_sys);
            if (ioctl_wr) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({ioctl_addr, ioctl_dout} !== {e.addr, e.data}) begin
                    n_bad++;
                    $display("FAIL ra_wr: got %0h/%0h want %0h/%0h",
                             ioctl_addr, ioctl_dout, e.addr, e.data);
                end
                nwr++;
            end
            if (done) ndone++;
            if (nwr == 2) break;
            fire = src_valid && src_ready;
            if (fire && k < 4) begin
                e.addr = AW'(k);
                e.data = bytes[k];
                exp_q.push_back(e);
            end
            @(posedge clk_sys); #1;
            if (fire) begin
                k++;
                if (k < 4) src_data = bytes[k];
            end
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, src_ready, snk_valid, ioctl_download, ioctl_upload,
             ioctl_wr, ioctl_addr, ioctl_index, ioctl_dout} !== {(AW+23){1'b0}}) begin
            n_bad++;
            $display("FAIL ra_async: got busy %b dl %b addr %0h dout %0h want 0 (nwr %0d)",
                     busy, ioctl_download, ioctl_addr, ioctl_dout, nwr);
        end
        src_valid = 1'b0;
        repeat (3) begin
            @(negedge clk_sys);
            if (done) ndone++;
        end
        reset = 1'b1;
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++; $display("FAIL ra_nodone: got %0d want 0", ndone);
        end
        exp_q.delete();
        @(posedge clk_sys); #1;
        k = 0; nwr = 0;
        src_data  = nb[0];
        src_valid = 1'b1;
        start_cmd(1'b0, 8'h5B, AW'(2));
        for (int cyc = 0; cyc < 100 && tail != 0; cyc++) begin
            @(negedge clk_sys);
            if (ioctl_wr) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ra_extra_wr: got wr at %0h want none", ioctl_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ioctl_addr, ioctl_dout} !== {e.addr, e.data}) begin
                        n_bad++;
                        $display("FAIL ra_restart: got %0h/%0h want %0h/%0h",
                                 ioctl_addr, ioctl_dout, e.addr, e.data);
                    end
                end
                nwr++;
            end
            if (done) begin
                ndone++;
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
            fire = src_valid && src_ready;
            if (fire && k < 2) begin
                e.addr = AW'(k);
                e.data = nb[k];
                exp_q.push_back(e);
            end
            @(posedge clk_sys); #1;
            if (fire) begin
                k++;
                if (k < 2) src_data = nb[k];
                else src_valid = 1'b0;
            end
        end
        n_cmp++;
        if (nwr !== 2 || ndone !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ra_second: got wr %0d done %0d busy %b want 2/1/0",
                     nwr, ndone, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        exp_t e;
        int k = 0, nwr = 0, ndone = 0, drop = 0, gap_wr = 0, ul_hi = 0, inv = 0;
        int tail = -1;
        logic fire;
        exp_q.delete();
        src_data  = bytes[0];
        src_valid = 1'b1;
        start_cmd(1'b0, 8'h33, AW'(5));
        for (int cyc = 0; cyc < 300 && tail != 0; cyc++) begin
            @(negedge clk_sys);
            if (ioctl_upload) ul_hi++;
            if (ioctl_wr && !ioctl_download) inv++;
            if (ioctl_wr && drop > 0 && exp_q.size() == 0) gap_wr++;
            if (ioctl_wr) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL bb_extra_wr: got wr at %0h want none", ioctl_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ioctl_addr, ioctl_dout} !== {e.addr, e.data}) begin
                        n_bad++;
                        $display("FAIL bb_wr: got %0h/%0h want %0h/%0h",
                                 ioctl_addr, ioctl_dout, e.addr, e.data);
                    end
                end
                nwr++;
            end
            if (done) begin
                ndone++;
                if (tail < 0) tail = 8;
            end
            if (tail > 0) tail--;
            fire = src_valid && src_ready;
            if (fire && k < 5) begin
                e.addr = AW'(k);
                e.data = bytes[k];
                exp_q.push_back(e);
            end
            @(posedge clk_sys); #1;
            if (cyc == 3) begin
                cmd_upload = 1'b1;
                cmd_index  = 8'h77;
                cmd_len    = AW'(1);
                cmd_start  = 1'b1;
            end else begin
                cmd_start = 1'b0;
            end
            if (fire) begin
                k++;
                if (k < 5) src_data = bytes[k];
                else src_valid = 1'b0;
                if (k == 2) begin
                    src_valid = 1'b0;
                    drop = 4;
                end
            end else if (drop > 0) begin
                drop--;
                if (drop == 0) src_valid = 1'b1;
            end
        end
        cmd_start = 1'b0;
        n_cmp++;
        if (nwr !== 5 || ndone !== 1) begin
            n_bad++; $display("FAIL bb_count: got wr %0d done %0d want 5/1", nwr, ndone);
        end
        n_cmp++;
        if (gap_wr + ul_hi + inv !== 0) begin
            n_bad++;
            $display("FAIL bb_gap: got gap %0d ul %0d inv %0d want 0", gap_wr, ul_hi, inv);
        end
        n_cmp++;
        if (ioctl_index !== 8'h33 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bb_ignored: got idx %0h busy %b want 33/0", ioctl_index, busy);
        end
    endtask

    initial begin
        test_reset();
        test_download();
        test_wait();
        test_upload();
        test_zero_len();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
